crossbar_rr_arbiter: RTL

- Per-slave round-robin arbiter that generates the grant matrix for the 4x4 crossbar commutation block.
- Decodes each master's target slave from the top address bits and, per slave, grants one requesting master.
- Holds each grant until the slave-side session-finished pulse arrives.
- Sits between the master request ports and the commutation block's granted_matrix and session_is_finished signals.

---
 rtl/crossbar_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 35 +++
 rtl/crossbar_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_arb_pkg.sv
// Shared types and sizing helpers for the crossbar round-robin arbiter.
// Contents: per-slave FSM state enum, default crossbar geometry,
// slave-select width helper and the grant row type.
package crossbar_arb_pkg;

    // Default crossbar geometry; ADDR_WIDTH mirrors the master interface width.
    localparam int unsigned QTY_OF_DEVICES = 4;
    localparam int unsigned ADDR_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Number of address MSBs needed to select one of n slaves.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [QTY_OF_DEVICES-1:0] grant_row_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// above ptr, wrapping modulo N.
// Ports: req (request vector), ptr (search start), onehot (winner as one-hot,
// zero when no request), idx (winner index, zero when no request).
module rr_picker
    import crossbar_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    // Rotating scan starting at ptr; first hit wins.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + 32'(i)) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/crossbar_rr_arbiter.sv
// Per-slave round-robin arbiter producing the crossbar grant matrix.
// Each slave runs an IDLE/GRANTED/RELEASE FSM; a grant is held until the
// slave's session_is_finished pulse, followed by one dead RELEASE cycle.
// Build option: define ARB_TIMEOUT_EN to add a per-grant watchdog
// (TIMEOUT_CYCLES) and the timeout_pulse output.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   master_req           - per-master request level
//   master_addr          - per-master address; MSBs select the slave
//   session_is_finished  - per-slave end-of-transaction pulse
//   granted_matrix       - registered; [s][m]=1 connects slave s to master m
//   slave_busy           - registered; slave s holds a grant
//   timeout_pulse        - (ARB_TIMEOUT_EN only) one-cycle forced-release flag
module crossbar_rr_arbiter
    import crossbar_arb_pkg::*;
#(
    parameter int unsigned QTY_OF_DEVICES = crossbar_arb_pkg::QTY_OF_DEVICES,
    parameter int unsigned ADDR_WIDTH     = crossbar_arb_pkg::ADDR_WIDTH,
    parameter int unsigned SEL_WIDTH      = sel_width(QTY_OF_DEVICES)
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [QTY_OF_DEVICES-1:0]                     master_req,
    input  logic [QTY_OF_DEVICES-1:0][ADDR_WIDTH-1:0]     master_addr,
    input  logic [QTY_OF_DEVICES-1:0]                     session_is_finished,
    output logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0] granted_matrix,
    output logic [QTY_OF_DEVICES-1:0]                     slave_busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic [QTY_OF_DEVICES-1:0]                     timeout_pulse
`endif
);

    localparam int unsigned Q = QTY_OF_DEVICES;

    arb_state_t           state    [Q];
    arb_state_t           state_nx [Q];
    logic [SEL_WIDTH-1:0] ptr      [Q];
    logic [SEL_WIDTH-1:0] ptr_nx   [Q];
    logic [SEL_WIDTH-1:0] win      [Q];
    logic [SEL_WIDTH-1:0] win_nx   [Q];
    logic [Q-1:0][Q-1:0]  grant_nx;
    logic [Q-1:0]         busy_nx;

    logic [Q-1:0]         held;
    logic [Q-1:0]         req_vec  [Q];
    logic [Q-1:0]         pick_oh  [Q];
    logic [SEL_WIDTH-1:0] pick_idx [Q];
    logic                 addr_lsbs_unused;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt    [Q];
    logic [CNT_W-1:0] cnt_nx [Q];
    logic [Q-1:0]     pulse_nx;
`endif

    // Masters already connected anywhere are masked so each holds at most one grant.
    always_comb begin
        held = '0;
        for (int s = 0; s < Q; s++) begin
            held = held | granted_matrix[s];
        end
    end

    // Decode target slave per master and build per-slave request vectors.
    always_comb begin
        for (int s = 0; s < Q; s++) begin
            req_vec[s] = '0;
            for (int m = 0; m < Q; m++) begin
                req_vec[s][m] = master_req[m] && !held[m] &&
                                (master_addr[m][ADDR_WIDTH-1 -: SEL_WIDTH] == SEL_WIDTH'(s));
            end
        end
    end

    // Address bits below the slave select carry no arbitration meaning.
    always_comb begin
        addr_lsbs_unused = 1'b0;
        for (int m = 0; m < Q; m++) begin
            addr_lsbs_unused = addr_lsbs_unused ^ (^master_addr[m][ADDR_WIDTH-SEL_WIDTH-1:0]);
        end
    end

    for (genvar s = 0; s < Q; s++) begin : g_pick
        rr_picker #(.N(Q), .IW(SEL_WIDTH)) u_pick (
            .req    (req_vec[s]),
            .ptr    (ptr[s]),
            .onehot (pick_oh[s]),
            .idx    (pick_idx[s])
        );
    end

    // Per-slave next-state and next-output logic.
    always_comb begin
        logic rel;
        rel = 1'b0;
        for (int s = 0; s < Q; s++) begin
            state_nx[s] = state[s];
            ptr_nx[s]   = ptr[s];
            win_nx[s]   = win[s];
            grant_nx[s] = granted_matrix[s];
            busy_nx[s]  = slave_busy[s];
`ifdef ARB_TIMEOUT_EN
            cnt_nx[s]   = cnt[s];
            pulse_nx[s] = 1'b0;
`endif
            rel = 1'b0;
            unique case (state[s])
                IDLE: begin
                    if (|req_vec[s]) begin
                        state_nx[s] = GRANTED;
                        grant_nx[s] = pick_oh[s];
                        busy_nx[s]  = 1'b1;
                        win_nx[s]   = pick_idx[s];
`ifdef ARB_TIMEOUT_EN
                        cnt_nx[s]   = '0;
`endif
                    end
                end
                GRANTED: begin
                    rel = session_is_finished[s];
`ifdef ARB_TIMEOUT_EN
                    // Finished on the limit cycle takes priority over the watchdog.
                    if (!session_is_finished[s] && cnt[s] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rel         = 1'b1;
                        pulse_nx[s] = 1'b1;
                    end else begin
                        cnt_nx[s] = cnt[s] + CNT_W'(1);
                    end
`endif
                    if (rel) begin
                        state_nx[s] = RELEASE;
                        grant_nx[s] = '0;
                        busy_nx[s]  = 1'b0;
                        ptr_nx[s]   = (win[s] == SEL_WIDTH'(Q - 1)) ? '0 : win[s] + SEL_WIDTH'(1);
                    end
                end
                RELEASE: state_nx[s] = IDLE;
                default: state_nx[s] = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < Q; s++) begin
                state[s] <= IDLE;
                ptr[s]   <= '0;
                win[s]   <= '0;
`ifdef ARB_TIMEOUT_EN
                cnt[s]   <= '0;
`endif
            end
            granted_matrix <= '0;
            slave_busy     <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_pulse  <= '0;
`endif
        end else begin
            for (int s = 0; s < Q; s++) begin
                state[s] <= state_nx[s];
                ptr[s]   <= ptr_nx[s];
                win[s]   <= win_nx[s];
`ifdef ARB_TIMEOUT_EN
                cnt[s]   <= cnt_nx[s];
`endif
            end
            granted_matrix <= grant_nx;
            slave_busy     <= busy_nx;
`ifdef ARB_TIMEOUT_EN
            timeout_pulse  <= pulse_nx;
`endif
        end
    end

    // Column invariant: a master is connected to at most one slave.
    logic col_ok_c;
    always_comb begin
        logic [Q-1:0] col;
        col      = '0;
        col_ok_c = 1'b1;
        for (int m = 0; m < Q; m++) begin
            for (int s = 0; s < Q; s++) begin
                col[s] = granted_matrix[s][m];
            end
            if ($countones(col) > 1) begin
                col_ok_c = 1'b0;
            end
        end
    end

    a_one_grant_per_master: assert property (@(posedge clk) disable iff (rst) col_ok_c);

endmodule
